// File: rtl/rv_mux_pkg.sv
// Shared definitions for the registered N:1 mux with skid buffer:
// default sizing and the occupancy state encoding.
package rv_mux_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_NUM_INPUTS = 4;

   // Occupancy of the two-entry output stage.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_t;

endpackage : rv_mux_pkg

// File: rtl/muxn_skid_if.sv
// Handshake and data bundle for muxn_skid: upstream valid/ready with the
// flattened inputs and select, downstream valid/ready with y and sel_err.
interface muxn_skid_if #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_INPUTS = 4,
   parameter int SEL_WIDTH  = $clog2(NUM_INPUTS)
) ();

   logic                             in_valid;
   logic                             in_ready;
   logic [SEL_WIDTH-1:0]             sel;
   logic [NUM_INPUTS*DATA_WIDTH-1:0] data_in;
   logic                             out_valid;
   logic                             out_ready;
   logic [DATA_WIDTH-1:0]            y;
   logic                             sel_err;

   modport master (
      output in_valid, sel, data_in, out_ready,
      input  in_ready, out_valid, y, sel_err
   );

   modport slave (
      input  in_valid, sel, data_in, out_ready,
      output in_ready, out_valid, y, sel_err
   );

endinterface : muxn_skid_if

// File: rtl/muxn_sel.sv
// Combinational N:1 selector with range check; out-of-range selects
// return DEFAULT_VALUE and flag err.
module muxn_sel
   import rv_mux_pkg::*;
#(
   parameter int                    DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int                    NUM_INPUTS    = DEFAULT_NUM_INPUTS,
   parameter int                    SEL_WIDTH     = $clog2(NUM_INPUTS),
   parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = '0
) (
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_in,
   input  logic [SEL_WIDTH-1:0]             sel,
   output logic [DATA_WIDTH-1:0]            data,
   output logic                             err
);

   // Equality against each legal index keeps the range check free of
   // mixed-width comparisons; no match means sel >= NUM_INPUTS.
   always_comb begin
      data = DEFAULT_VALUE;
      err  = 1'b1;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         if (sel == SEL_WIDTH'(k)) begin
            data = data_in[k*DATA_WIDTH +: DATA_WIDTH];
            err  = 1'b0;
         end
      end
   end

endmodule : muxn_sel

// File: rtl/muxn_skid.sv
// Registered N:1 mux with a two-entry skid stage; in_ready depends only on
// registered state so there is no combinational path from out_ready.
module muxn_skid
   import rv_mux_pkg::*;
#(
   parameter int                    DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int                    NUM_INPUTS    = DEFAULT_NUM_INPUTS,
   parameter int                    SEL_WIDTH     = $clog2(NUM_INPUTS),
   parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = '0
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        en,
   muxn_skid_if.slave  bus
);

   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_err_c;

   skid_state_t           state_p1;
   skid_state_t           state_nxt;
   logic                  alive_p1;
   logic [DATA_WIDTH-1:0] main_data_p1;
   logic                  main_err_p1;
   logic [DATA_WIDTH-1:0] skid_data_p1;
   logic                  skid_err_p1;

   logic                  in_ready_c;
   logic                  out_valid_c;
   logic                  accept;
   logic                  deliver;
   logic                  ld_main_in;
   logic                  ld_main_skid;
   logic                  ld_skid;

   muxn_sel #(
      .DATA_WIDTH    (DATA_WIDTH),
      .NUM_INPUTS    (NUM_INPUTS),
      .SEL_WIDTH     (SEL_WIDTH),
      .DEFAULT_VALUE (DEFAULT_VALUE)
   ) u_sel (
      .data_in (bus.data_in),
      .sel     (bus.sel),
      .data    (sel_data),
      .err     (sel_err_c)
   );

   // alive_p1 keeps in_ready low until the first enabled edge after reset.
   assign in_ready_c  = en & alive_p1 & (state_p1 != ST_TWO);
   assign out_valid_c = (state_p1 == ST_ONE) | (state_p1 == ST_TWO);
   assign accept      = en & bus.in_valid & in_ready_c;
   assign deliver     = en & out_valid_c & bus.out_ready;

   always_comb begin
      state_nxt    = state_p1;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      unique case (state_p1)
         ST_EMPTY: begin
            if (accept) begin
               state_nxt  = ST_ONE;
               ld_main_in = 1'b1;
            end
         end
         ST_ONE: begin
            if (accept && deliver) begin
               ld_main_in = 1'b1;
            end else if (accept) begin
               state_nxt = ST_TWO;
               ld_skid   = 1'b1;
            end else if (deliver) begin
               state_nxt = ST_EMPTY;
            end
         end
         ST_TWO: begin
            // in_ready is low here, so only a deliver can happen.
            if (deliver) begin
               state_nxt    = ST_ONE;
               ld_main_skid = 1'b1;
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
   end

   // ---- stage p1: occupancy and entry registers ----
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_p1     <= ST_EMPTY;
         alive_p1     <= 1'b0;
         main_data_p1 <= DEFAULT_VALUE;
         main_err_p1  <= 1'b0;
         skid_data_p1 <= '0;
         skid_err_p1  <= 1'b0;
      end else begin
         state_p1 <= state_nxt;
         if (en) begin
            alive_p1 <= 1'b1;
         end
         if (ld_main_in) begin
            main_data_p1 <= sel_data;
            main_err_p1  <= sel_err_c;
         end else if (ld_main_skid) begin
            main_data_p1 <= skid_data_p1;
            main_err_p1  <= skid_err_p1;
         end
         if (ld_skid) begin
            skid_data_p1 <= sel_data;
            skid_err_p1  <= sel_err_c;
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.y         = main_data_p1;
   assign bus.sel_err   = main_err_p1;

endmodule : muxn_skid

// File: doc/muxn_skid.md
MUXN_SKID -- requirements
Module: muxn_skid

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of each data input and of y.
REQ-002 SHALL have parameter NUM_INPUTS, default 4, number of selectable inputs, legal range 2..16.
REQ-003 SHALL have parameter SEL_WIDTH, default $clog2(NUM_INPUTS), width of sel.
REQ-004 SHALL have parameter DEFAULT_VALUE, default 0, value returned for an out-of-range sel.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port en, input, 1, global enable; 0 freezes all state.
REQ-008 SHALL have port in_valid, input, 1, an upstream beat is offered.
REQ-009 SHALL have port in_ready, output, 1, the block can accept a beat.
REQ-010 SHALL have port sel, input, SEL_WIDTH, index of the input to capture.
REQ-011 SHALL have port data_in, input, NUM_INPUTS*DATA_WIDTH, flattened inputs; input k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port out_valid, output, 1, y holds a valid beat.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts y.
REQ-014 SHALL have port y, output, DATA_WIDTH, the selected data.
REQ-015 SHALL have port sel_err, output, 1, the beat on y came from an out-of-range sel.

Function
REQ-016 SHALL accept a beat on a rising edge when en=1, in_valid=1 and in_ready=1; it SHALL deliver a beat on a rising edge when en=1, out_valid=1 and out_ready=1.
REQ-017 SHALL capture data_in slice sel with sel_err=0 when sel<NUM_INPUTS; otherwise it SHALL capture DEFAULT_VALUE with sel_err=1.
REQ-018 SHALL register its output: an accepted beat appears on y/out_valid on the next cycle (latency 1).
REQ-019 SHALL hold two entries, main (drives y) and skid, with states EMPTY, ONE (main full) and TWO (main and skid full).
REQ-020 SHALL transition EMPTY->ONE on accept; ONE->EMPTY on deliver without accept; ONE->ONE on simultaneous accept and deliver (main reloaded); ONE->TWO on accept without deliver (beat goes to skid); TWO->ONE on deliver (skid moves to main).
REQ-021 SHALL drive in_ready = en AND NOT(state==TWO) from registered state only, with no combinational path from out_ready.
REQ-022 SHALL drive out_valid=1 exactly in states ONE and TWO, and hold y and sel_err stable while out_valid=1 and out_ready=0.
REQ-023 SHALL preserve beat order, with no loss and no duplication, under any in_valid/out_ready pattern.
REQ-024 SHALL, when en=0, hold state, main, skid and outputs unchanged, drive in_ready=0, and ignore out_ready.
REQ-025 SHALL keep y at its last value when in EMPTY; y is don't-care to consumers while out_valid=0.

Reset
REQ-026 SHALL, on rstn=0 and independent of clk, force state EMPTY, out_valid=0, in_ready=0, y=DEFAULT_VALUE, sel_err=0 and clear the skid entry.
REQ-027 SHALL discard any in-flight beats when reset is asserted mid-operation.
REQ-028 SHALL allow in_ready to rise no earlier than the first rising edge after rstn deasserts.

Structure
REQ-029 SHALL take the DATA_WIDTH and NUM_INPUTS defaults and the state encoding (EMPTY/ONE/TWO, 2 bits) from shared package rv_mux_pkg.
REQ-030 SHALL implement selection and range check in one combinational sub-module muxn_sel (data_in, sel -> data, err); the state machine and registers stay in muxn_skid.

Verification
REQ-031 SHALL pass this scenario: reset, then NUM_INPUTS=4 with inputs 0x11/0x22/0x33/0x44, sel=2, in_valid pulse, out_ready=1 -> next cycle y=0x33, out_valid=1, sel_err=0.
REQ-032 SHALL pass this scenario: NUM_INPUTS=3, sel=3 -> y=DEFAULT_VALUE, sel_err=1.
REQ-033 SHALL pass this scenario: out_ready=0 with beats A and B offered back-to-back -> state TWO, in_ready=0, y=A held; then out_ready=1 -> A, then B, delivered in order.
REQ-034 SHALL pass this scenario: continuous in_valid=1 and out_ready=1 for 20 cycles -> one beat delivered per cycle, in_ready constant 1.
REQ-035 SHALL pass this scenario: en=0 for 5 cycles in state TWO -> no output change and in_ready=0; on re-enable, both beats are delivered intact.
REQ-036 SHALL pass this scenario: rstn asserted mid-cycle in state TWO -> immediately out_valid=0 and y=DEFAULT_VALUE; no stale beat appears after release.
